alu_selftest_driver: RTL and testbench

Synthesizable self-test engine that sits on the ALU's input side and drives its operand/control ports from an internal vector table, then samples `ALU_result`/`sig_branch` and checks them against expected values. It is the hardware counterpart of the ALU bench: it can run on silicon/FPGA after reset to prove the ALU datapath before the core is released. It reports pass/fail, a failure count and the index of the first failing vector.

---
 rtl/alu_selftest_driver.sv | 161 ++++++++++++++++
 tb/tb_alu_selftest_driver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_selftest_driver.sv
// Self-test engine for the ALU: drives a fixed vector table onto the ALU inputs, samples the
// result after a settle window and reports pass/fail, failure count and first failing index.
module alu_selftest_driver #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_VEC       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  opcode,
    output logic [31:0] rs_content,
    output logic [31:0] rt_content,
    output logic [4:0]  shamt,
    output logic [5:0]  ALU_control,
    output logic [15:0] immediate,
    input  logic [31:0] ALU_result,
    input  logic        sig_branch,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [2:0]  first_fail_idx
);

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp;
    } vec_t;

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);
    localparam logic [2:0] LastIdx    = 3'(NUM_VEC - 1);

    // Expected sig_branch is 0 for every entry, so only the result is tabulated.
    function automatic vec_t vec_lookup(input logic [2:0] i);
        vec_t v;
        unique case (i)
            3'd0:    v = '{ctl: 6'b100010, rs: 32'd52,         rt: 32'd4,  exp: 32'd48};
            3'd1:    v = '{ctl: 6'b100010, rs: 32'd150,        rt: 32'd25, exp: 32'd125};
            3'd2:    v = '{ctl: 6'b100010, rs: 32'd74,         rt: 32'd12, exp: 32'd62};
            3'd3:    v = '{ctl: 6'b100010, rs: 32'd15,         rt: 32'd15, exp: 32'd0};
            3'd4:    v = '{ctl: 6'b100010, rs: 32'd10,         rt: 32'd20, exp: 32'hFFFF_FFF6};
            3'd5:    v = '{ctl: 6'b100010, rs: 32'd0,          rt: 32'd7,  exp: 32'hFFFF_FFF9};
            3'd6:    v = '{ctl: 6'b100000, rs: 32'd7,          rt: 32'd8,  exp: 32'd15};
            default: v = '{ctl: 6'b100000, rs: 32'hFFFF_FFFF,  rt: 32'd1,  exp: 32'd0};
        endcase
        return v;
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  fail_q, fail_d;
    logic [2:0]  first_q, first_d;
    logic [5:0]  ctl_q, ctl_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;

    vec_t cur_vec;
    vec_t nxt_vec;
    vec_t first_vec;
    logic mismatch;

    always_comb begin
        cur_vec   = vec_lookup(idx_q);
        nxt_vec   = vec_lookup(idx_q + 3'd1);
        first_vec = vec_lookup(3'd0);
        mismatch  = (ALU_result != cur_vec.exp) || sig_branch;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        first_d = first_q;
        ctl_d   = ctl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWait;
                    idx_d   = 3'd0;
                    cnt_d   = SettleInit;
                    fail_d  = 4'd0;
                    first_d = 3'd0;
                    ctl_d   = first_vec.ctl;
                    rs_d    = first_vec.rs;
                    rt_d    = first_vec.rt;
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    fail_d = fail_q + 4'd1;
                    if (fail_q == 4'd0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = SettleInit;
                    ctl_d   = nxt_vec.ctl;
                    rs_d    = nxt_vec.rs;
                    rt_d    = nxt_vec.rt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            fail_q  <= 4'd0;
            first_q <= 3'd0;
            ctl_q   <= 6'd0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            ctl_q   <= ctl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    // opcode, shamt and immediate are zero in every table entry and at reset.
    assign opcode         = 6'd0;
    assign shamt          = 5'd0;
    assign immediate      = 16'd0;
    assign ALU_control    = ctl_q;
    assign rs_content     = rs_q;
    assign rt_content     = rt_q;
    assign busy           = (state_q == StWait) || (state_q == StCheck);
    assign done           = (state_q == StDone);
    assign pass           = done && (fail_q == 4'd0);
    assign fail_count     = fail_q;
    assign first_fail_idx = first_q;

endmodule

// File: tb/tb_alu_selftest_driver.sv
// Bench for alu_selftest_driver: behavioural ALU models with injectable faults, a vector-level
// reference of expected outcomes, and registered-ALU instances for the settle-window checks.
module tb_alu_selftest_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Table inputs and expected results as written in the specification.
    logic [5:0]  ref_ctl [8] = '{6'b100010, 6'b100010, 6'b100010, 6'b100010,
                                 6'b100010, 6'b100010, 6'b100000, 6'b100000};
    logic [31:0] ref_rs  [8] = '{32'd52, 32'd150, 32'd74, 32'd15, 32'd10, 32'd0, 32'd7,
                                 32'hFFFF_FFFF};
    logic [31:0] ref_rt  [8] = '{32'd4, 32'd25, 32'd12, 32'd15, 32'd20, 32'd7, 32'd8, 32'd1};
    logic [31:0] ref_exp [8] = '{32'd48, 32'd125, 32'd62, 32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFF9,
                                 32'd15, 32'd0};

    // 0: correct ALU, 1: result bit 0 stuck-at-1, 2: per-vector xor mask / branch flip
    int          mode = 0;
    logic [31:0] err_res [8];
    logic        err_br  [8];

    function automatic logic [31:0] alu_fn(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        if (c == 6'b100010) return a - b;
        if (c == 6'b100000) return a + b;
        return 32'd0;
    endfunction

    logic [5:0]  op0, ctl0, op1, ctl1, op2, ctl2;
    logic [31:0] rs0, rt0, rs1, rt1, rs2, rt2;
    logic [4:0]  sh0, sh1, sh2;
    logic [15:0] imm0, imm1, imm2;
    logic [31:0] res0, res1, res2a, res2;
    logic        br0;
    logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [3:0]  fc0, fc1, fc2;
    logic [2:0]  ffi0, ffi1, ffi2;

    always_comb begin
        int hit;
        hit = -1;
        for (int i = 0; i < 8; i++) begin
            if (ctl0 == ref_ctl[i] && rs0 == ref_rs[i] && rt0 == ref_rt[i]) hit = i;
        end
        res0 = alu_fn(ctl0, rs0, rt0);
        br0  = 1'b0;
        if (mode == 1) begin
            res0 = res0 | 32'd1;
        end else if (mode == 2 && hit >= 0) begin
            res0 = res0 ^ err_res[hit];
            br0  = err_br[hit];
        end
    end

    always_ff @(posedge clk) begin
        res1  <= alu_fn(ctl1, rs1, rt1);
        res2a <= alu_fn(ctl2, rs2, rt2);
        res2  <= res2a;
    end

    alu_selftest_driver dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(op0), .rs_content(rs0),
        .rt_content(rt0), .shamt(sh0), .ALU_control(ctl0), .immediate(imm0),
        .ALU_result(res0), .sig_branch(br0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fc0), .first_fail_idx(ffi0)
    );

    alu_selftest_driver #(.SETTLE_CYCLES(1), .NUM_VEC(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(op1), .rs_content(rs1),
        .rt_content(rt1), .shamt(sh1), .ALU_control(ctl1), .immediate(imm1),
        .ALU_result(res1), .sig_branch(1'b0), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_idx(ffi1)
    );

    alu_selftest_driver #(.SETTLE_CYCLES(1), .NUM_VEC(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(op2), .rs_content(rs2),
        .rt_content(rt2), .shamt(sh2), .ALU_control(ctl2), .immediate(imm2),
        .ALU_result(res2), .sig_branch(1'b0), .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fc2), .first_fail_idx(ffi2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then wait for dut0 done; lat = edges from the start edge to done.
    task automatic run_once(input bit probe, output int lat, output int busy_cnt);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!done0 && n < 100) begin
            if (busy0) busy_cnt++;
            if (probe && n == 1) begin
                chk("vec0_rs", rs0, 32'd52);
                chk("vec0_rt", rt0, 32'd4);
                chk("vec0_ctl", {26'd0, ctl0}, 32'b100010);
            end
            if (probe && n == 16) begin
                chk("vec5_rs", rs0, 32'd0);
                chk("vec5_rt", rt0, 32'd7);
            end
            @(negedge clk);
            n++;
        end
        lat = n - 1;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, bc, exp_fc, exp_ffi, n;
        for (int i = 0; i < 8; i++) begin
            err_res[i] = 32'd0;
            err_br[i]  = 1'b0;
        end

        // Reset state
        reset_all();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_fc", fc0, 0);
        chk("rst_ffi", ffi0, 0);
        chk("rst_rs", rs0, 0);
        chk("rst_rt", rt0, 0);
        chk("rst_ctl", ctl0, 0);
        chk("rst_op_sh_imm", {op0, sh0, imm0}, 0);

        // Correct ALU
        mode = 0;
        run_once(1'b1, lat, bc);
        chk("good_latency", lat, 24);
        chk("good_busy_cycles", bc, 24);
        chk("good_pass", pass0, 1);
        chk("good_fc", fc0, 0);
        chk("done_holds_rs", rs0, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        chk("done_held", done0, 1);
        chk("done_not_busy", busy0, 0);

        // Result bit 0 stuck-at-1
        mode = 1;
        exp_fc = 0; exp_ffi = 0;
        for (int i = 0; i < 8; i++) begin
            if ((ref_exp[i] | 32'd1) != ref_exp[i]) begin
                if (exp_fc == 0) exp_ffi = i;
                exp_fc++;
            end
        end
        run_once(1'b0, lat, bc);
        chk("stuck_fc", fc0, 5);
        chk("stuck_fc_model", fc0, exp_fc);
        chk("stuck_ffi", ffi0, exp_ffi);
        chk("stuck_pass", pass0, 0);

        // sig_branch asserted only on vector 4
        mode = 2;
        err_br[4] = 1'b1;
        run_once(1'b0, lat, bc);
        chk("br4_fc", fc0, 1);
        chk("br4_ffi", ffi0, 4);
        chk("br4_pass", pass0, 0);
        err_br[4] = 1'b0;

        // Random faults on random vectors
        for (int it = 0; it < 8; it++) begin
            exp_fc = 0; exp_ffi = 0;
            for (int i = 0; i < 8; i++) begin
                err_res[i] = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 31))
                                                         : 32'd0;
                err_br[i]  = ($urandom_range(0, 4) == 0);
                if (err_res[i] != 0 || err_br[i]) begin
                    if (exp_fc == 0) exp_ffi = i;
                    exp_fc++;
                end
            end
            run_once(1'b0, lat, bc);
            chk($sformatf("rand%0d_fc", it), fc0, exp_fc);
            chk($sformatf("rand%0d_ffi", it), ffi0, exp_ffi);
            chk($sformatf("rand%0d_pass", it), pass0, (exp_fc == 0));
            chk($sformatf("rand%0d_latency", it), lat, 24);
        end
        for (int i = 0; i < 8; i++) begin
            err_res[i] = 32'd0;
            err_br[i]  = 1'b0;
        end
        mode = 0;

        // Reset during vector 3's WAIT
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun_vec3_rs", rs0, 32'd15);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_rst_busy", busy0, 0);
        chk("midrun_rst_done", done0, 0);
        chk("midrun_rst_rs", rs0, 0);
        chk("midrun_rst_ctl", ctl0, 0);
        chk("midrun_rst_fc", fc0, 0);
        run_once(1'b0, lat, bc);
        chk("rerun_latency", lat, 24);
        chk("rerun_pass", pass0, 1);

        // start held high across a whole run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n = 1;
        while (!done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_latency", n - 1, 24);
        @(negedge clk);
        chk("held_done_pulse", done0, 0);
        chk("held_restart_busy", busy0, 1);
        chk("held_restart_rs", rs0, 32'd52);
        start = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_second_pass", pass0, 1);

        // SETTLE_CYCLES=1 against 1-cycle and 2-cycle registered ALUs
        reset_all();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        lat = -1;
        while (!(done1 && done2) && n < 100) begin
            @(negedge clk);
            n++;
            if (done1 && lat < 0) lat = n - 1;
        end
        chk("s1_reg1_latency", lat, 16);
        chk("s1_reg1_pass", pass1, 1);
        chk("s1_reg1_fc", fc1, 0);
        chk("s1_reg2_done", done2, 1);
        chk("s1_reg2_pass", pass2, 0);
        chk("s1_reg2_fc_nonzero", (fc2 != 4'd0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
